// File: rtl/if_id_buf_pkg.sv
// Shared pipeline constants for the MIPS core: word widths, instruction field positions and the NOP encoding.
package pipe_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } ifid_entry_t;

endpackage

// File: rtl/if_id_buf_if.sv
// Fetch/decode handshake bundle for the IF/ID buffer; master is the fetch+decode side, slave is the buffer.
interface if_id_buf_if;
  import pipe_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [PC_W-1:0]    in_pc;
  logic [INSTR_W-1:0] in_instr;
  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    out_pc;
  logic [INSTR_W-1:0] out_instr;
  logic [5:0]         out_opcode;
  logic [4:0]         out_rs;
  logic [4:0]         out_rt;
  logic [4:0]         out_rd;
  logic [15:0]        out_imm16;

  modport master (
    output in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_instr,
           out_opcode, out_rs, out_rt, out_rd, out_imm16
  );

  modport slave (
    input  in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_instr,
           out_opcode, out_rs, out_rt, out_rd, out_imm16
  );

endinterface

// File: rtl/if_id_buf_fifo.sv
// Parameterized valid/ready FIFO of {pc, instr} entries with a flush that empties it in one edge.
module if_id_fifo
  import pipe_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  ifid_entry_t in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output ifid_entry_t out_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  ifid_entry_t      mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  // Readiness comes from the registered count only, so a pop never frees a slot in the same cycle.
  assign in_ready  = (count < CNT_W'(DEPTH)) && !flush;
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !flush;
  assign out_data  = mem[head];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[tail] <= in_data;
        tail      <= tail + PTR_W'(1);
      end
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: rtl/if_id_buf.sv
// IF/ID pipeline buffer: FIFO plus NOP masking, field split and an optional decode stall counter
// (enabled by defining IFID_STALL_CNT_EN; otherwise stall_cnt is tied to zero).
module if_id_buf
  import pipe_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  if_id_buf_if.slave  bus,
  output logic [31:0] stall_cnt
);

  ifid_entry_t wr_entry;
  ifid_entry_t head_entry;
  logic        head_valid;
  logic        head_ready;

  assign wr_entry.pc    = bus.in_pc;
  assign wr_entry.instr = bus.in_instr;
  assign head_ready     = bus.out_ready;

  if_id_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (wr_entry),
    .out_valid (head_valid),
    .out_ready (head_ready),
    .out_data  (head_entry)
  );

  // An empty buffer presents a NOP at PC 0 so decode sees clean zeros rather than stale storage.
  assign bus.out_valid  = head_valid;
  assign bus.out_pc     = head_valid ? head_entry.pc    : '0;
  assign bus.out_instr  = head_valid ? head_entry.instr : NOP_INSTR;
  assign bus.out_opcode = bus.out_instr[OPC_HI:OPC_LO];
  assign bus.out_rs     = bus.out_instr[RS_HI:RS_LO];
  assign bus.out_rt     = bus.out_instr[RT_HI:RT_LO];
  assign bus.out_rd     = bus.out_instr[RD_HI:RD_LO];
  assign bus.out_imm16  = bus.out_instr[IMM_HI:IMM_LO];

`ifdef IFID_STALL_CNT_EN
  // Saturating back-pressure counter; flush leaves it alone, only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (head_valid && !head_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`else
  assign stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_if_id_buf.sv
// Scoreboard bench for if_id_buf: directed stimulus pushes expected entries, a negedge monitor checks pops.
module tb_if_id_buf;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [31:0] stall_cnt;

  if_id_buf_if ifc ();

  if_id_buf #(.DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .bus       (ifc),
    .stall_cnt (stall_cnt)
  );

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int          mcount = 0;
  logic [31:0] mstall = 0;
  logic [31:0] stream_instr [8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] expStall();
`ifdef IFID_STALL_CNT_EN
    return mstall;
`else
    return 32'h0;
`endif
  endfunction

  // One clock of stimulus: drive, check handshake state against the model, update model, advance.
  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                               input logic rdy, input logic fl);
    logic exp_rdy;
    logic push;
    logic pop;
    exp_t e;
    ifc.in_valid  = v;
    ifc.in_pc     = pc;
    ifc.in_instr  = instr;
    ifc.out_ready = rdy;
    flush         = fl;
    #1;
    exp_rdy = (mcount < 2) && !fl;
    checkOutput("in_ready", {31'b0, ifc.in_ready}, {31'b0, exp_rdy});
    checkOutput("out_valid", {31'b0, ifc.out_valid}, {31'b0, mcount != 0});
    checkOutput("stall_cnt", stall_cnt, expStall());
    if (mcount > 0 && !rdy && mstall != 32'hFFFF_FFFF) mstall++;
    if (fl) begin
      mcount = 0;
      sb.delete();
    end else begin
      push = v && exp_rdy;
      pop  = (mcount > 0) && rdy;
      if (push) begin
        e.pc    = pc;
        e.instr = instr;
        sb.push_back(e);
      end
      mcount = mcount + int'(push) - int'(pop);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted pop is compared against the scoreboard head; idle outputs must be zero.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ifc.out_valid && ifc.out_ready && !flush) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL pop_unexpected: got pc=%h expected no entry", ifc.out_pc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("out_pc", ifc.out_pc, e.pc);
          checkOutput("out_instr", ifc.out_instr, e.instr);
          checkOutput("out_opcode", {26'b0, ifc.out_opcode}, (e.instr >> 26) & 32'h3F);
          checkOutput("out_rs", {27'b0, ifc.out_rs}, (e.instr >> 21) & 32'h1F);
          checkOutput("out_rt", {27'b0, ifc.out_rt}, (e.instr >> 16) & 32'h1F);
          checkOutput("out_rd", {27'b0, ifc.out_rd}, (e.instr >> 11) & 32'h1F);
          checkOutput("out_imm16", {16'b0, ifc.out_imm16}, e.instr & 32'hFFFF);
        end
      end else if (!ifc.out_valid) begin
        checkOutput("idle_zero", {31'b0, |{ifc.out_pc, ifc.out_instr, ifc.out_opcode, ifc.out_rs,
                                          ifc.out_rt, ifc.out_rd, ifc.out_imm16}}, 32'h0);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    stream_instr[0] = 32'h2008_0001;
    stream_instr[1] = 32'h2009_0002;
    stream_instr[2] = 32'h0109_5020;
    stream_instr[3] = 32'hAC0A_0010;
    stream_instr[4] = 32'h8C0B_0010;
    stream_instr[5] = 32'h116A_FFFB;
    stream_instr[6] = 32'h0800_0100;
    stream_instr[7] = 32'h0000_0000;

    rst_n         = 1'b0;
    flush         = 1'b0;
    ifc.in_valid  = 1'b0;
    ifc.in_pc     = '0;
    ifc.in_instr  = '0;
    ifc.out_ready = 1'b0;
    #3;
    checkOutput("rst_in_ready", {31'b0, ifc.in_ready}, 32'h1);
    checkOutput("rst_out_valid", {31'b0, ifc.out_valid}, 32'h0);
    checkOutput("rst_out_instr", ifc.out_instr, 32'h0);
    checkOutput("rst_stall_cnt", stall_cnt, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // addi $t0,$zero,-1 then one pop
    applyStimulus(1'b1, 32'h0040_0000, 32'h2008_FFFF, 1'b0, 1'b0);
    checkOutput("t1_opcode", {26'b0, ifc.out_opcode}, 32'h08);
    checkOutput("t1_rs", {27'b0, ifc.out_rs}, 32'h0);
    checkOutput("t1_rt", {27'b0, ifc.out_rt}, 32'h8);
    checkOutput("t1_imm16", {16'b0, ifc.out_imm16}, 32'hFFFF);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Fill, then pop with in_valid high: no push while full
    applyStimulus(1'b1, 32'h0040_0004, 32'h8C09_0004, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h0040_0008, 32'h012A_5820, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h0040_000C, 32'h3C01_DEAD, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Streaming at full rate
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 32'h0040_1000 + 32'(4 * i), stream_instr[i], 1'b1, 1'b0);
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Flush with two entries buffered, alongside in_valid and out_ready
    applyStimulus(1'b1, 32'h0040_2000, 32'h2010_1234, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h0040_2004, 32'h2011_5678, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h0040_2008, 32'h2012_9ABC, 1'b1, 1'b1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Five stall cycles, flush, then asynchronous reset mid-cycle
    applyStimulus(1'b1, 32'h0040_3000, 32'h2013_0007, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    applyStimulus(1'b1, 32'h0040_3004, 32'h2014_0008, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_stall_cnt", stall_cnt, 32'h0);
    checkOutput("midrst_out_valid", {31'b0, ifc.out_valid}, 32'h0);
    checkOutput("midrst_in_ready", {31'b0, ifc.in_ready}, 32'h1);
    mstall = 0;
    mcount = 0;
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    checkOutput("sb_empty", sb.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
